draw_start_screen: RTL
======================

DRAW_START_SCREEN -- requirements
Module: draw_start_screen

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: ROM address width, formed as {vcount[9:0], hcount[9:0]}.
REQ-002 Parameter DATA_WIDTH, default 12: ROM pixel width, RGB 4:4:4 as {r[11:8], g[7:4], b[3:0]}.
REQ-003 Parameter FRAME_STEP, default 4: number of frames per fade level increment; legal range 1..255.
REQ-004 clk  in  1: posedge active clock, the pixel clock; single clock domain.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 enable  in  1: start screen selected by the game FSM.
REQ-007 hcount_in, vcount_in  in  11 each: VGA pixel counters.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each: VGA timing strobes.
REQ-009 rgb_in  in  12: upstream pixel, passed through when enable=0.
REQ-010 rom_addr  out  ADDR_WIDTH: address to the start-screen ROM; the ROM returns data 1 clk later.
REQ-011 rom_data  in  DATA_WIDTH: ROM read data.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1: timing delayed by 3 clk.
REQ-013 rgb_out  out  12: final pixel.

Function
REQ-014 rom_addr SHALL be registered: rom_addr <= {vcount_in[9:0], hcount_in[9:0]} each clk (stage 1).
REQ-015 rom_data SHALL be consumed in stage 2, aligned with timing delayed by 2 clk.
REQ-016 All *_out timing signals SHALL equal the matching *_in signals delayed by exactly 3 clk, through a 3-deep register pipeline.
REQ-017 rgb_out SHALL be registered (stage 3) and aligned with the delayed timing.
REQ-018 enable SHALL be sampled into the pipeline with the timing, so the source mux switches on a pixel-exact boundary.
REQ-019 If delayed enable=0, rgb_out SHALL be rgb_in delayed by 3 clk, unmodified.
REQ-020 If delayed enable=1 and delayed hblnk or vblnk is 1, rgb_out SHALL be 12'h000.
REQ-021 Otherwise, each 4-bit channel c of rom_data SHALL be output as (c*(level+1))>>4, computed in 8 bits and truncated to 4 bits. level=15 yields c unchanged.
REQ-022 Frame start SHALL be the cycle in which hcount_in==0 and vcount_in==0.
REQ-023 Fade FSM states: IDLE, FADE, HOLD. level is a 4-bit register and frame_cnt is an 8-bit register.
REQ-024 IDLE: level=0 and frame_cnt=0. On a frame start with enable=1, the FSM SHALL go to FADE.
REQ-025 FADE: on each frame start, frame_cnt increments. When frame_cnt reaches FRAME_STEP-1, frame_cnt clears and level increments. When level increments from 14 to 15, the FSM SHALL go to HOLD.
REQ-026 HOLD: level SHALL stay at 15.
REQ-027 From any state, enable=0 SHALL force IDLE, level=0 and frame_cnt=0 on the next clk. This rule takes priority over a simultaneous frame start.
REQ-028 level SHALL change only on a frame-start cycle (except the clear in REQ-027), so no mid-frame brightness tear occurs.
REQ-029 level SHALL saturate at 15 and never wrap to 0.
REQ-030 level SHALL be sampled into the stage-2 arithmetic together with the aligned pixel.

Reset
REQ-031 While rst_n=0 at a clk edge, all pipeline registers, rom_addr, rgb_out and all *_out signals SHALL become 0, the FSM SHALL become IDLE, and level and frame_cnt SHALL become 0.
REQ-032 Reset asserted mid-frame or mid-fade SHALL abort the fade. After release, the FSM SHALL wait in IDLE for the next frame start with enable=1.
REQ-033 Outputs SHALL become valid from the 3rd clk after reset release.

Verification
REQ-034 Latency: hcount_in=5, vcount_in=7 at cycle N -> rom_addr=20'h01C05 at N+1; hcount_out=5 and vcount_out=7 at N+3.
REQ-035 Pass-through: enable=0, rgb_in=12'hABC -> rgb_out=12'hABC 3 clk later, regardless of rom_data.
REQ-036 Fade: FRAME_STEP=1, enable=1, rom_data=12'hFFF -> at frame 1 the output per channel is 4'h1 (rgb_out=12'h111); HOLD is reached after 15 frame starts, and then rgb_out=12'hFFF.
REQ-037 Blanking: enable=1 in HOLD, hblnk_in=1 -> rgb_out=12'h000 3 clk later, while hsync_out follows hsync_in.
REQ-038 Abort: enable drops at level=8 during FADE -> next clk state=IDLE and level=0; re-enable restarts the fade from level 0 at the next frame start.
REQ-039 Reset mid-fade: rst_n=0 for 1 clk at level=10 -> all outputs 0, IDLE, level=0; timing outputs resume 3 clk after release.

Source files
------------

// File: rtl/draw_start_screen_if.sv
// Pixel-stream bundle for the start-screen fader: upstream VGA timing and pixel,
// ROM port, delayed timing and final pixel, plus FSM debug taps.
interface draw_start_screen_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12
);
  // Streaming, no backpressure: every clk carries one pixel and nothing can
  // stall; each output lags its input by exactly 3 clk, rom_data lags rom_addr by 1.
  logic                  enable;
  logic [10:0]           hcount_in;
  logic [10:0]           vcount_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  hblnk_in;
  logic                  vblnk_in;
  logic [11:0]           rgb_in;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [10:0]           hcount_out;
  logic [10:0]           vcount_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  hblnk_out;
  logic                  vblnk_out;
  logic [11:0]           rgb_out;
  logic [1:0]            dbg_state;  // 0 IDLE, 1 FADE, 2 HOLD
  logic [3:0]            dbg_level;

  modport slave (
    input  enable, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, rom_data,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
           vblnk_out, rgb_out, dbg_state, dbg_level
  );

  modport master (
    output enable, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, rom_data,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
           vblnk_out, rgb_out, dbg_state, dbg_level
  );
endinterface

// File: rtl/draw_start_screen.sv
// Start screen: 3-stage pipeline reading a pixel ROM, fading it in per frame,
// blanking outside the active area and passing rgb_in through when not selected.
module draw_start_screen #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12,
  parameter int FRAME_STEP = 4
) (
  input logic clk,
  input logic rst_n,
  draw_start_screen_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FADE = 2'd1, S_HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } tim_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(FRAME_STEP - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_level, w_level_nxt;
  logic [7:0]            r_frame_cnt, w_cnt_nxt;
  logic                  w_frame_start;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  tim_t                  r_t1, r_t2, r_t3;
  logic                  r_en1, r_en2;
  logic [11:0]           r_rgb1, r_rgb2, r_rgb_out, w_rgb_nxt;
  logic [3:0]            r_level2;

  // c*(level+1)>>4 in 8 bits; level 15 leaves the channel unchanged
  function automatic logic [3:0] f_scale(input logic [3:0] c, input logic [3:0] lvl);
    return 4'(({4'd0, c} * ({4'd0, lvl} + 8'd1)) >> 4);
  endfunction

  assign w_frame_start = (io_bus.hcount_in == 11'd0) && (io_bus.vcount_in == 11'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_level     <= 4'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_frame_cnt <= w_cnt_nxt;
    end
  end

  // enable low wins over a coincident frame start; level moves only on frame starts
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_frame_cnt;
    if (!io_bus.enable) begin
      w_state_nxt = S_IDLE;
      w_level_nxt = 4'd0;
      w_cnt_nxt   = 8'd0;
    end else if (w_frame_start) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_FADE;
          w_level_nxt = 4'd0;
          w_cnt_nxt   = 8'd0;
        end
        S_FADE: begin
          if (r_frame_cnt == LP_CNT_LAST) begin
            w_cnt_nxt   = 8'd0;
            w_level_nxt = r_level + 4'd1;
            if (r_level == 4'd14) w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
        S_HOLD:  w_level_nxt = 4'd15;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rgb_nxt = r_rgb2;
    if (r_en2) begin
      if (r_t2.hb || r_t2.vb) w_rgb_nxt = 12'h000;
      else w_rgb_nxt = {f_scale(io_bus.rom_data[11:8], r_level2),
                        f_scale(io_bus.rom_data[7:4], r_level2),
                        f_scale(io_bus.rom_data[3:0], r_level2)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_t3       <= '0;
      r_en1      <= 1'b0;
      r_en2      <= 1'b0;
      r_rgb1     <= 12'h000;
      r_rgb2     <= 12'h000;
      r_level2   <= 4'd0;
      r_rgb_out  <= 12'h000;
    end else begin
      r_rom_addr <= ADDR_WIDTH'({io_bus.vcount_in[9:0], io_bus.hcount_in[9:0]});
      r_t1       <= {io_bus.hcount_in, io_bus.vcount_in, io_bus.hsync_in,
                     io_bus.vsync_in, io_bus.hblnk_in, io_bus.vblnk_in};
      r_en1      <= io_bus.enable;
      r_rgb1     <= io_bus.rgb_in;
      r_t2       <= r_t1;
      r_en2      <= r_en1;
      r_rgb2     <= r_rgb1;
      r_level2   <= r_level;
      r_t3       <= r_t2;
      r_rgb_out  <= w_rgb_nxt;
    end
  end

  assign io_bus.rom_addr   = r_rom_addr;
  assign io_bus.hcount_out = r_t3.h;
  assign io_bus.vcount_out = r_t3.v;
  assign io_bus.hsync_out  = r_t3.hs;
  assign io_bus.vsync_out  = r_t3.vs;
  assign io_bus.hblnk_out  = r_t3.hb;
  assign io_bus.vblnk_out  = r_t3.vb;
  assign io_bus.rgb_out    = r_rgb_out;
  assign io_bus.dbg_state  = r_state;
  assign io_bus.dbg_level  = r_level;
endmodule
